// File: rtl/alu_pkg.sv
// Shared opcode and flag types for the pipelined ALU and anything reusing alu_core.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'h0,
      OP_SUB   = 4'h1,
      OP_AND   = 4'h2,
      OP_OR    = 4'h3,
      OP_XOR   = 4'h4,
      OP_NAND  = 4'h5,
      OP_NOR   = 4'h6,
      OP_ZERO  = 4'h7,
      OP_SHL   = 4'h8,
      OP_SHR   = 4'h9,
      OP_SRA   = 4'hA,
      OP_SLT   = 4'hB,
      OP_SLTU  = 4'hC,
      OP_ADC   = 4'hD,
      OP_RSV_E = 4'hE,
      OP_RSV_F = 4'hF
   } alu_op_e;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } alu_flags_t;

   // Only the adder-class operations commit their carry to the sticky register.
   function automatic logic op_writes_carry(alu_op_e op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result, flags and reserved-opcode error from (a, b, op, carry_in).
// Zero latency, no handshake; the caller owns any registering and carry state.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_e          op,
   input  logic             carry_in,
   output logic [WIDTH-1:0] result,
   output alu_flags_t       flags,
   output logic             op_err
);

   logic [SHW-1:0] sh;
   logic           cin_eff;
   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;
   logic [WIDTH:0] shl_w;
   logic [WIDTH:0] shr_w;
   logic [WIDTH:0] sra_w;
   logic           c;
   logic           v;

   assign sh      = b[SHW-1:0];
   assign cin_eff = (op == OP_ADC) ? carry_in : 1'b0;
   assign sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_eff};
   assign diff    = {1'b0, a} - {1'b0, b};

   // One guard bit beyond the operand catches the last bit shifted out;
   // it stays 0 for a zero shift amount.
   assign shl_w   = {1'b0, a} << sh;
   assign shr_w   = {a, 1'b0} >> sh;
   assign sra_w   = $unsigned($signed({a, 1'b0}) >>> sh);

   always_comb begin
      result = '0;
      c      = 1'b0;
      v      = 1'b0;
      op_err = 1'b0;
      case (op)
         OP_ADD, OP_ADC: begin
            result = sum[WIDTH-1:0];
            c      = sum[WIDTH];
            v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            result = diff[WIDTH-1:0];
            c      = diff[WIDTH];
            v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NAND: result = ~(a & b);
         OP_NOR:  result = ~(a | b);
         OP_ZERO: result = '0;
         OP_SHL: begin
            result = shl_w[WIDTH-1:0];
            c      = shl_w[WIDTH];
         end
         OP_SHR: begin
            result = shr_w[WIDTH:1];
            c      = shr_w[0];
         end
         OP_SRA: begin
            result = sra_w[WIDTH:1];
            c      = sra_w[0];
         end
         OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
         default: op_err = 1'b1;
      endcase
   end

   always_comb begin
      flags   = '0;
      flags.z = (result == '0);
      flags.n = result[WIDTH-1];
      flags.c = c;
      flags.v = v;
   end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: stage 1 registers operands, stage 2 computes and holds result/flags.
// Latency 2 cycles, 1 beat/cycle; in_ready falls combinationally when both stages are held.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v,
   output logic             op_err
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   alu_op_e          s1_op;
   logic             carry_q;
   logic             s1_en;
   logic             s2_en;
   logic [WIDTH-1:0] core_result;
   alu_flags_t       core_flags;
   logic             core_err;
   alu_flags_t       flags_q;

   assign s2_en    = !out_valid || out_ready;
   assign s1_en    = !s1_valid || s2_en;
   assign in_ready = s1_en;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .a        (s1_a),
      .b        (s1_b),
      .op       (s1_op),
      .carry_in (carry_q),
      .result   (core_result),
      .flags    (core_flags),
      .op_err   (core_err)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_op     <= OP_ADD;
         out_valid <= 1'b0;
         result    <= '0;
         flags_q   <= '0;
         op_err    <= 1'b0;
         carry_q   <= 1'b0;
      end else begin
         if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_a  <= a;
               s1_b  <= b;
               s1_op <= alu_op_e'(opcode);
            end
         end
         // Carry commits in the same stage that consumes it, so ADD->ADC needs no bubble.
         if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               result  <= core_result;
               flags_q <= core_flags;
               op_err  <= core_err;
               if (op_writes_carry(s1_op))
                  carry_q <= core_flags.c;
            end
         end
      end
   end

   assign flag_z = flags_q.z;
   assign flag_n = flags_q.n;
   assign flag_c = flags_q.c;
   assign flag_v = flags_q.v;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=8): directed literal cases plus randomized traffic with back-pressure,
// every emitted beat compared against an arithmetic model fed in stream order.
module tb_alu_pipe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic [3:0] opcode = 4'h0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] result;
   logic       flag_z, flag_n, flag_c, flag_v, op_err;

   int n_total = 0;
   int n_pass  = 0;
   int n_out   = 0;

   typedef struct {
      int r;
      int f;
      int e;
   } exp_t;

   exp_t q[$];
   int   mcarry = 0;
   int   held_vld = 0;
   int   held_r = 0;
   int   held_f = 0;

   alu_pipe #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .opcode    (opcode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flag_z    (flag_z),
      .flag_n    (flag_n),
      .flag_c    (flag_c),
      .flag_v    (flag_v),
      .op_err    (op_err)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   function automatic int sx(input int u);
      return (u >= 128) ? u - 256 : u;
   endfunction

   // Reference behaviour from the opcode rules, in plain integer arithmetic.
   task automatic model(input int ua, input int ub, input int op, input int cin,
                        output int r, output int f, output int e, output int cout);
      int s, sa, sb, c, v, t;
      sa = sx(ua); sb = sx(ub); s = ub % 8;
      c = 0; v = 0; e = 0; r = 0;
      case (op)
         0, 13: begin
            t = ua + ub + ((op == 13) ? cin : 0);
            r = t % 256; c = t / 256;
            t = sa + sb + ((op == 13) ? cin : 0);
            v = (t > 127 || t < -128) ? 1 : 0;
         end
         1: begin
            r = (ua - ub + 256) % 256; c = (ua < ub) ? 1 : 0;
            t = sa - sb;
            v = (t > 127 || t < -128) ? 1 : 0;
         end
         2: r = ua & ub;
         3: r = ua | ub;
         4: r = ua ^ ub;
         5: r = 255 - (ua & ub);
         6: r = 255 - (ua | ub);
         7: r = 0;
         8: begin r = (ua << s) % 256; c = (s == 0) ? 0 : (ua >> (8 - s)) % 2; end
         9: begin r = ua >> s; c = (s == 0) ? 0 : (ua >> (s - 1)) % 2; end
         10: begin r = (sa >>> s) & 255; c = (s == 0) ? 0 : (ua >> (s - 1)) % 2; end
         11: r = (sa < sb) ? 1 : 0;
         12: r = (ua < ub) ? 1 : 0;
         default: e = 1;
      endcase
      f = ((r == 0) ? 8 : 0) + ((r >= 128) ? 4 : 0) + c * 2 + v;
      cout = (op == 0 || op == 1 || op == 13) ? c : cin;
   endtask

   always @(negedge clk) begin
      exp_t ex;
      int   nc;
      if (!rst_n) begin
         q.delete();
         mcarry   = 0;
         held_vld = 0;
      end else begin
         if (held_vld != 0) begin
            chk("hold_result", result, held_r);
            chk("hold_flags", {flag_z, flag_n, flag_c, flag_v}, held_f);
         end
         held_vld = (out_valid && !out_ready) ? 1 : 0;
         held_r   = result;
         held_f   = {flag_z, flag_n, flag_c, flag_v};
         if (out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) begin
               chk("spurious_beat", 1, 0);
            end else begin
               ex = q.pop_front();
               chk("sb_result", result, ex.r);
               chk("sb_flags", {flag_z, flag_n, flag_c, flag_v}, ex.f);
               chk("sb_op_err", op_err, ex.e);
            end
         end
         if (in_valid && in_ready) begin
            model(a, b, opcode, mcarry, ex.r, ex.f, ex.e, nc);
            mcarry = nc;
            q.push_back(ex);
         end
      end
   end

   task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic [3:0] vop);
      logic acc;
      a = va; b = vb; opcode = vop; in_valid = 1'b1; acc = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   task automatic dir(input string name, input logic [7:0] va, input logic [7:0] vb,
                      input logic [3:0] vop, input int er, input int ef, input int ee);
      int found;
      found = 0;
      send(va, vb, vop);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (out_valid) begin
            found = k;
            break;
         end
      end
      chk({name, "_lat"}, found, 2);
      chk({name, "_res"}, result, er);
      chk({name, "_flags"}, {flag_z, flag_n, flag_c, flag_v}, ef);
      chk({name, "_err"}, op_err, ee);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] rnd_opnd();
      case ($urandom_range(0, 5))
         0: return 8'h00;
         1: return 8'hFF;
         2: return 8'h80;
         3: return 8'h7F;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      int base;
      logic acc;

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {flag_z, flag_n, flag_c, flag_v, op_err}, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // flags literal is {z,n,c,v}
      dir("add_f0_20", 8'hF0, 8'h20, 4'h0, 8'h10, 4'b0010, 0);
      dir("adc_after_add", 8'h00, 8'h00, 4'hD, 8'h01, 4'b0000, 0);
      dir("sub_80_01", 8'h80, 8'h01, 4'h1, 8'h7F, 4'b0001, 0);
      dir("slt_ff_01", 8'hFF, 8'h01, 4'hB, 8'h01, 4'b0000, 0);
      dir("sltu_ff_01", 8'hFF, 8'h01, 4'hC, 8'h00, 4'b1000, 0);
      dir("shl_81_1", 8'h81, 8'h01, 4'h8, 8'h02, 4'b0010, 0);
      dir("sra_80_3", 8'h80, 8'h03, 4'hA, 8'hF0, 4'b0100, 0);
      dir("shr_by_0", 8'h5A, 8'h00, 4'h9, 8'h5A, 4'b0000, 0);
      dir("add_ff_01", 8'hFF, 8'h01, 4'h0, 8'h00, 4'b1010, 0);
      dir("rsv_e", 8'h12, 8'h34, 4'hE, 8'h00, 4'b1000, 1);
      dir("adc_keeps_c", 8'h00, 8'h00, 4'hD, 8'h01, 4'b0000, 0);

      // Back-pressure: two beats fill the pipe, the third must stall.
      base = n_out;
      out_ready = 1'b0;
      a = 8'h10; b = 8'h01; opcode = 4'h0; in_valid = 1'b1;
      @(negedge clk); chk("bp_rdy_beat1", in_ready, 1);
      @(posedge clk); #1;
      a = 8'h20;
      @(negedge clk); chk("bp_rdy_beat2", in_ready, 1);
      @(posedge clk); #1;
      a = 8'h30;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); chk("bp_stall", in_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      send(8'h30, 8'h01, 4'h0);
      send(8'h40, 8'h01, 4'h0);
      repeat (4) @(posedge clk);
      #1;
      chk("bp_count", n_out - base, 4);
      chk("bp_queue_empty", q.size(), 0);

      // Reset with two beats in flight must drop them and clear the sticky carry.
      dir("add_set_c", 8'hFF, 8'h01, 4'h0, 8'h00, 4'b1010, 0);
      out_ready = 1'b0;
      send(8'h01, 8'h01, 4'h0);
      send(8'hFF, 8'hFF, 4'h0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_flags", {flag_z, flag_n, flag_c, flag_v, op_err}, 0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      dir("adc_after_rst", 8'h00, 8'h00, 4'hD, 8'h00, 4'b1000, 0);

      // Randomized traffic; valid is held until accepted.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
         if (acc || !in_valid) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a = rnd_opnd();
            b = rnd_opnd();
            opcode = ($urandom_range(0, 3) == 0) ? 4'hD : 4'($urandom_range(0, 15));
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
      #1;
      chk("final_drain", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
